// File: rtl/n1_dsp_pkg.sv
// Shared DSP-partition definitions: stack-pointer width and the stack AGU
// operation encoding with its per-channel priority decode.
package n1_dsp_pkg;

    localparam int N1_DSP_SP_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_PSH,
        OP_PUL,
        OP_REPL,
        OP_RST
    } agu_op_t;

    // Clear beats everything; a simultaneous push and pull is a top-of-stack replace.
    function automatic agu_op_t decode_op(input logic rst, input logic psh, input logic pul);
        agu_op_t op;
        if (rst) begin
            op = OP_RST;
        end else if (psh && pul) begin
            op = OP_REPL;
        end else if (psh) begin
            op = OP_PSH;
        end else if (pul) begin
            op = OP_PUL;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/n1_dsp_stack_agu_ch.sv
// One stack address generator channel: fill-level counter, sticky error flags
// and a registered stack pointer derived from the next level.
module n1_dsp_stack_agu_ch
    import n1_dsp_pkg::*;
#(
    parameter int                  SP_WIDTH = N1_DSP_SP_WIDTH,
    parameter int                  DEPTH    = 255,
    parameter bit                  DOWN     = 1'b0,
    parameter logic [SP_WIDTH-1:0] BASE     = '0
) (
    input  logic                clk_i,
    input  logic                async_rst_b_i,
    input  logic                psh_i,
    input  logic                pul_i,
    input  logic                rst_i,
    input  logic                err_clr_i,
    output logic [SP_WIDTH-1:0] sp_o,
    output logic [SP_WIDTH-1:0] lvl_o,
    output logic                empty_o,
    output logic                full_o,
    output logic                ovf_o,
    output logic                unf_o
);

    localparam logic [SP_WIDTH-1:0] DEPTH_L = SP_WIDTH'(DEPTH);
    localparam logic [SP_WIDTH-1:0] ONE     = SP_WIDTH'(1);

    logic [SP_WIDTH-1:0] lvl_q, lvl_nxt;
    logic [SP_WIDTH-1:0] sp_q, sp_nxt;
    logic                ovf_q, ovf_nxt;
    logic                unf_q, unf_nxt;
    logic                full_w, empty_w;
    agu_op_t             op;

    assign full_w  = (lvl_q == DEPTH_L);
    assign empty_w = (lvl_q == '0);

    // Error clear is applied first so that an error raised this cycle still sets the flag.
    always_comb begin
        op      = decode_op(rst_i, psh_i, pul_i);
        lvl_nxt = lvl_q;
        ovf_nxt = ovf_q & ~err_clr_i;
        unf_nxt = unf_q & ~err_clr_i;
        case (op)
            OP_RST: begin
                lvl_nxt = '0;
                ovf_nxt = 1'b0;
                unf_nxt = 1'b0;
            end
            OP_PSH: begin
                if (full_w) begin
                    ovf_nxt = 1'b1;
                end else begin
                    lvl_nxt = lvl_q + ONE;
                end
            end
            OP_PUL: begin
                if (empty_w) begin
                    unf_nxt = 1'b1;
                end else begin
                    lvl_nxt = lvl_q - ONE;
                end
            end
            default: begin
            end
        endcase
        sp_nxt = DOWN ? (BASE - lvl_nxt) : (BASE + lvl_nxt);
    end

    always_ff @(posedge clk_i or negedge async_rst_b_i) begin
        if (!async_rst_b_i) begin
            lvl_q <= '0;
            sp_q  <= BASE;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            lvl_q <= lvl_nxt;
            sp_q  <= sp_nxt;
            ovf_q <= ovf_nxt;
            unf_q <= unf_nxt;
        end
    end

    assign sp_o    = sp_q;
    assign lvl_o   = lvl_q;
    assign empty_o = empty_w;
    assign full_o  = full_w;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: rtl/n1_dsp_stack_agu.sv
// CH independent stack AGUs with per-channel growth direction, packed into
// flat output buses (channel n at [n*SP_WIDTH +: SP_WIDTH]).
module n1_dsp_stack_agu
    import n1_dsp_pkg::*;
#(
    parameter int                  CH       = 2,
    parameter int                  SP_WIDTH = N1_DSP_SP_WIDTH,
    parameter int                  DEPTH    = 255,
    parameter logic [CH-1:0]       DIR_DOWN = 'b01,
    parameter logic [SP_WIDTH-1:0] BASE     = '0
) (
    input  logic                   clk_i,
    input  logic                   async_rst_b_i,
    input  logic [CH-1:0]          psh_i,
    input  logic [CH-1:0]          pul_i,
    input  logic [CH-1:0]          rst_i,
    input  logic [CH-1:0]          err_clr_i,
    output logic [CH*SP_WIDTH-1:0] sp_o,
    output logic [CH*SP_WIDTH-1:0] lvl_o,
    output logic [CH-1:0]          empty_o,
    output logic [CH-1:0]          full_o,
    output logic [CH-1:0]          ovf_o,
    output logic [CH-1:0]          unf_o
);

    for (genvar n = 0; n < CH; n++) begin : g_ch
        n1_dsp_stack_agu_ch #(
            .SP_WIDTH (SP_WIDTH),
            .DEPTH    (DEPTH),
            .DOWN     (DIR_DOWN[n]),
            .BASE     (BASE)
        ) u_ch (
            .clk_i         (clk_i),
            .async_rst_b_i (async_rst_b_i),
            .psh_i         (psh_i[n]),
            .pul_i         (pul_i[n]),
            .rst_i         (rst_i[n]),
            .err_clr_i     (err_clr_i[n]),
            .sp_o          (sp_o[n*SP_WIDTH +: SP_WIDTH]),
            .lvl_o         (lvl_o[n*SP_WIDTH +: SP_WIDTH]),
            .empty_o       (empty_o[n]),
            .full_o        (full_o[n]),
            .ovf_o         (ovf_o[n]),
            .unf_o         (unf_o[n])
        );
    end

endmodule

// File: tb/tb_n1_dsp_stack_agu.sv
// Randomised and directed checks of n1_dsp_stack_agu against a simple
// level/flag model, plus a DEPTH=1 instance for the degenerate case.
module tb_n1_dsp_stack_agu;

    localparam int         CH     = 2;
    localparam int         SPW    = 8;
    localparam int         DEPTH  = 4;
    localparam logic [1:0] DIRS   = 2'b01;
    localparam int         BASE_A = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [CH-1:0]     psh = '0, pul = '0, rst = '0, clr = '0;
    logic [CH*SPW-1:0] sp, lvl;
    logic [CH-1:0]     empty, full, ovf, unf;

    logic [0:0]     b_psh = '0, b_pul = '0, b_rst = '0, b_clr = '0;
    logic [SPW-1:0] b_sp, b_lvl;
    logic [0:0]     b_empty, b_full, b_ovf, b_unf;

    int n_vec = 0;
    int n_err = 0;

    int m_lvl[CH];
    bit m_ovf[CH];
    bit m_unf[CH];

    n1_dsp_stack_agu #(
        .CH(CH), .SP_WIDTH(SPW), .DEPTH(DEPTH), .DIR_DOWN(DIRS), .BASE(8'(BASE_A))
    ) dut (
        .clk_i(clk), .async_rst_b_i(rst_n),
        .psh_i(psh), .pul_i(pul), .rst_i(rst), .err_clr_i(clr),
        .sp_o(sp), .lvl_o(lvl), .empty_o(empty), .full_o(full), .ovf_o(ovf), .unf_o(unf)
    );

    n1_dsp_stack_agu #(
        .CH(1), .SP_WIDTH(SPW), .DEPTH(1), .DIR_DOWN(1'b1), .BASE(8'h10)
    ) dut_d1 (
        .clk_i(clk), .async_rst_b_i(rst_n),
        .psh_i(b_psh), .pul_i(b_pul), .rst_i(b_rst), .err_clr_i(b_clr),
        .sp_o(b_sp), .lvl_o(b_lvl), .empty_o(b_empty), .full_o(b_full), .ovf_o(b_ovf), .unf_o(b_unf)
    );

    always #5 clk = ~clk;

    function automatic int exp_sp(int ch);
        int s;
        s = DIRS[ch] ? (BASE_A - m_lvl[ch]) : (BASE_A + m_lvl[ch]);
        return s & 255;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_lvl[c] = 0;
            m_ovf[c] = 0;
            m_unf[c] = 0;
        end
    endtask

    // Drive one cycle of requests, advance the model at the edge, return #1 after it.
    task automatic applyStimulus(input logic [CH-1:0] p, input logic [CH-1:0] u,
                                 input logic [CH-1:0] r, input logic [CH-1:0] c);
        psh = p;
        pul = u;
        rst = r;
        clr = c;
        @(posedge clk);
        for (int k = 0; k < CH; k++) begin
            if (r[k]) begin
                m_lvl[k] = 0;
                m_ovf[k] = 0;
                m_unf[k] = 0;
            end else begin
                if (c[k]) begin
                    m_ovf[k] = 0;
                    m_unf[k] = 0;
                end
                if (p[k] && u[k]) begin
                end else if (p[k]) begin
                    if (m_lvl[k] == DEPTH) m_ovf[k] = 1;
                    else m_lvl[k] = m_lvl[k] + 1;
                end else if (u[k]) begin
                    if (m_lvl[k] == 0) m_unf[k] = 1;
                    else m_lvl[k] = m_lvl[k] - 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (sp !== 16'h0000) begin n_err++; $display("[TB] FAIL reset_sp got %h expected %h", sp, 16'h0000); end
        n_vec++;
        if (lvl !== 16'h0000) begin n_err++; $display("[TB] FAIL reset_lvl got %h expected %h", lvl, 16'h0000); end
        n_vec++;
        if (empty !== 2'b11) begin n_err++; $display("[TB] FAIL reset_empty got %b expected %b", empty, 2'b11); end
        n_vec++;
        if ({full, ovf, unf} !== 6'b0) begin n_err++; $display("[TB] FAIL reset_flags got %b expected %b", {full, ovf, unf}, 6'b0); end
        n_vec++;
        if (b_sp !== 8'h10) begin n_err++; $display("[TB] FAIL reset_d1_sp got %h expected %h", b_sp, 8'h10); end
        rst_n = 1'b1;
    endtask

    task automatic test_push_growth();
        repeat (3) applyStimulus(2'b11, 2'b00, 2'b00, 2'b00);
        n_vec++;
        if (sp[7:0] !== 8'hFD || exp_sp(0) != 8'hFD) begin n_err++; $display("[TB] FAIL push_ch0_sp got %h expected %h", sp[7:0], 8'hFD); end
        n_vec++;
        if (sp[15:8] !== 8'h03 || exp_sp(1) != 8'h03) begin n_err++; $display("[TB] FAIL push_ch1_sp got %h expected %h", sp[15:8], 8'h03); end
        n_vec++;
        if (lvl !== 16'h0303) begin n_err++; $display("[TB] FAIL push_lvl got %h expected %h", lvl, 16'h0303); end
        n_vec++;
        if (empty !== 2'b00) begin n_err++; $display("[TB] FAIL push_empty got %b expected %b", empty, 2'b00); end
    endtask

    task automatic test_overflow();
        applyStimulus(2'b00, 2'b00, 2'b11, 2'b00);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(2'b10, 2'b00, 2'b00, 2'b00);
            if (i == 4) begin
                n_vec++;
                if (full[1] !== 1'b1 || sp[15:8] !== 8'h04) begin n_err++; $display("[TB] FAIL ovf_full4 got full=%b sp=%h expected full=1 sp=04", full[1], sp[15:8]); end
                n_vec++;
                if (ovf[1] !== 1'b0) begin n_err++; $display("[TB] FAIL ovf_early got %b expected 0", ovf[1]); end
            end
        end
        n_vec++;
        if (sp[15:8] !== 8'h04 || ovf[1] !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_push5 got sp=%h ovf=%b expected sp=04 ovf=1", sp[15:8], ovf[1]); end
        n_vec++;
        if (ovf[0] !== 1'b0) begin n_err++; $display("[TB] FAIL ovf_isolation got %b expected 0", ovf[0]); end
    endtask

    task automatic test_underflow();
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b00);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00);
        n_vec++;
        if (unf[0] !== 1'b1 || sp[7:0] !== 8'h00) begin n_err++; $display("[TB] FAIL unf_set got unf=%b sp=%h expected unf=1 sp=00", unf[0], sp[7:0]); end
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b01);
        n_vec++;
        if (unf[0] !== 1'b0) begin n_err++; $display("[TB] FAIL unf_clear got %b expected 0", unf[0]); end
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b01);
        n_vec++;
        if (unf[0] !== 1'b1) begin n_err++; $display("[TB] FAIL unf_clr_collide got %b expected 1", unf[0]); end
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b11);
    endtask

    task automatic test_replace();
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b00);
        repeat (2) applyStimulus(2'b10, 2'b00, 2'b00, 2'b00);
        applyStimulus(2'b10, 2'b10, 2'b00, 2'b00);
        n_vec++;
        if (sp[15:8] !== 8'h02 || lvl[15:8] !== 8'h02) begin n_err++; $display("[TB] FAIL repl_hold got sp=%h lvl=%h expected 02/02", sp[15:8], lvl[15:8]); end
        n_vec++;
        if (ovf[1] !== 1'b0 || unf[1] !== 1'b0) begin n_err++; $display("[TB] FAIL repl_flags got %b%b expected 00", ovf[1], unf[1]); end
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b00);
        applyStimulus(2'b01, 2'b01, 2'b00, 2'b00);
        n_vec++;
        if (unf[0] !== 1'b0 || empty[0] !== 1'b1) begin n_err++; $display("[TB] FAIL repl_empty got unf=%b empty=%b expected 0/1", unf[0], empty[0]); end
        applyStimulus(2'b10, 2'b10, 2'b10, 2'b00);
        n_vec++;
        if (lvl[15:8] !== 8'h00 || sp[15:8] !== 8'(BASE_A)) begin n_err++; $display("[TB] FAIL repl_rst got lvl=%h sp=%h expected 00/%h", lvl[15:8], sp[15:8], 8'(BASE_A)); end
    endtask

    task automatic test_async_reset();
        applyStimulus(2'b00, 2'b00, 2'b11, 2'b00);
        repeat (5) applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b01, 2'b00, 2'b00);
        n_vec++;
        if (lvl[7:0] !== 8'h03 || ovf[0] !== 1'b1) begin n_err++; $display("[TB] FAIL arst_setup got lvl=%h ovf=%b expected 03/1", lvl[7:0], ovf[0]); end
        psh = '0; pul = '0; rst = '0; clr = '0;
        rst_n = 1'b0;
        model_reset();
        #2;
        n_vec++;
        if ({sp, lvl} !== 32'h0 || empty !== 2'b11 || {full, ovf, unf} !== 6'b0) begin
            n_err++;
            $display("[TB] FAIL arst_immediate got sp=%h lvl=%h empty=%b flags=%b expected 0000/0000/11/000000", sp, lvl, empty, {full, ovf, unf});
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        n_vec++;
        if (lvl[7:0] !== 8'h01 || sp[7:0] !== 8'hFF) begin n_err++; $display("[TB] FAIL arst_first_push got lvl=%h sp=%h expected 01/FF", lvl[7:0], sp[7:0]); end
    endtask

    task automatic test_depth_one();
        psh = '0; pul = '0; rst = '0; clr = '0;
        b_psh = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (b_full !== 1'b1 || b_empty !== 1'b0 || b_sp !== 8'h0F || b_lvl !== 8'h01) begin
            n_err++;
            $display("[TB] FAIL d1_push got full=%b empty=%b sp=%h lvl=%h expected 1/0/0F/01", b_full, b_empty, b_sp, b_lvl);
        end
        @(posedge clk); #1;
        n_vec++;
        if (b_ovf !== 1'b1 || b_lvl !== 8'h01) begin n_err++; $display("[TB] FAIL d1_ovf got ovf=%b lvl=%h expected 1/01", b_ovf, b_lvl); end
        b_psh = 1'b0; b_pul = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (b_empty !== 1'b1 || b_sp !== 8'h10 || b_unf !== 1'b0) begin n_err++; $display("[TB] FAIL d1_pull got empty=%b sp=%h unf=%b expected 1/10/0", b_empty, b_sp, b_unf); end
        @(posedge clk); #1;
        n_vec++;
        if (b_unf !== 1'b1) begin n_err++; $display("[TB] FAIL d1_unf got %b expected 1", b_unf); end
        b_pul = 1'b0;
    endtask

    task automatic test_random();
        logic [CH-1:0] r, c;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < CH; k++) begin
                r[k] = ($urandom_range(15) == 0);
                c[k] = ($urandom_range(7) == 0);
            end
            applyStimulus(CH'($urandom), CH'($urandom), r, c);
            for (int k = 0; k < CH; k++) begin
                n_vec++;
                if (lvl[k*SPW +: SPW] !== SPW'(m_lvl[k]) || sp[k*SPW +: SPW] !== SPW'(exp_sp(k))) begin
                    n_err++;
                    $display("[TB] FAIL rand_lvl_sp cyc=%0d ch=%0d got lvl=%h sp=%h expected lvl=%h sp=%h", i, k, lvl[k*SPW +: SPW], sp[k*SPW +: SPW], SPW'(m_lvl[k]), SPW'(exp_sp(k)));
                end
                n_vec++;
                if (empty[k] !== (m_lvl[k] == 0) || full[k] !== (m_lvl[k] == DEPTH) || ovf[k] !== m_ovf[k] || unf[k] !== m_unf[k]) begin
                    n_err++;
                    $display("[TB] FAIL rand_flags cyc=%0d ch=%0d got e/f/o/u=%b%b%b%b expected %b%b%b%b", i, k, empty[k], full[k], ovf[k], unf[k], (m_lvl[k] == 0), (m_lvl[k] == DEPTH), m_ovf[k], m_unf[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_growth();
        test_overflow();
        test_underflow();
        test_replace();
        test_async_reset();
        test_depth_one();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
